// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe_pkg.sv
// Shared constants and elaboration-time sizing helpers for the pipelined AND-reduction tree.
// Mode constants are only consumed when GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN is defined.
package gf180mcu_fd_sc_mcu7t5v0__andn_pipe_pkg;

   localparam logic MODE_AND = 1'b0;
   localparam logic MODE_OR  = 1'b1;

   function automatic int levels_for(input int width, input int fanin);
      int    lvl;
      longint span;
      lvl  = 1;
      span = longint'(fanin);
      while (span < longint'(width)) begin
         span = span * longint'(fanin);
         lvl  = lvl + 1;
      end
      return lvl;
   endfunction

   // Bits held by stage k: ceil(width / fanin^(k+1)).
   function automatic int stage_width(input int width, input int fanin, input int k);
      longint span;
      span = longint'(fanin);
      for (int j = 0; j < k; j++) begin
         span = span * longint'(fanin);
      end
      return int'((longint'(width) + span - 64'sd1) / span);
   endfunction

   // Offset of tree level k in the flattened bus; level 0 is the operand, level k+1 is stage k.
   function automatic int bit_offset(input int width, input int fanin, input int k);
      int off;
      off = 0;
      for (int j = 0; j < k; j++) begin
         off = off + ((j == 0) ? width : stage_width(width, fanin, j - 1));
      end
      return off;
   endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe_stage.sv
// One tree level: grouped reduction with identity padding, data/valid registers, ready chain.
// Mode register and OR support exist only under GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN.
module gf180mcu_fd_sc_mcu7t5v0__andn_pipe_stage
   import gf180mcu_fd_sc_mcu7t5v0__andn_pipe_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 4,
   parameter int FANIN = 4
) (
   input  logic             CLK,
   input  logic             RST,
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
   input  logic             in_mode_i,
   output logic             mode_o,
`endif
   input  logic [IN_W-1:0]  in_data_i,
   input  logic             in_valid_i,
   input  logic             next_ready_i,
   output logic             ready_o,
   output logic [OUT_W-1:0] data_o,
   output logic             valid_o
);

   localparam int PAD_W = OUT_W * FANIN;

   logic             pad_s;
   logic [PAD_W-1:0] padded_s;
   logic [OUT_W-1:0] red_s;
   logic [OUT_W-1:0] data_d, data_q;
   logic             valid_d, valid_q;

`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
   logic mode_d, mode_q;
   assign pad_s = (in_mode_i == MODE_OR) ? 1'b0 : 1'b1;
`else
   assign pad_s = 1'b1;
`endif

   assign ready_o = ~valid_q | next_ready_i;

   // Pad the tail group with the identity element, then reduce each FANIN-wide group.
   always_comb begin
      padded_s            = {PAD_W{pad_s}};
      padded_s[IN_W-1:0]  = in_data_i;
      red_s               = '0;
      for (int g = 0; g < OUT_W; g++) begin
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
         if (in_mode_i == MODE_OR) begin
            red_s[g] = |padded_s[g*FANIN +: FANIN];
         end else begin
            red_s[g] = &padded_s[g*FANIN +: FANIN];
         end
`else
         red_s[g] = &padded_s[g*FANIN +: FANIN];
`endif
      end
   end

   // Load from upstream whenever this stage is empty or downstream drains; otherwise hold.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
      mode_d  = mode_q;
`endif
      if (ready_o) begin
         data_d  = red_s;
         valid_d = in_valid_i;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
         mode_d  = in_mode_i;
`endif
      end else begin
         data_d  = data_q;
         valid_d = valid_q;
      end
   end

   // Stage registers, cleared asynchronously.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_q  <= '0;
         valid_q <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
         mode_q  <= MODE_AND;
`endif
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
         mode_q  <= mode_d;
`endif
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
   assign mode_o  = mode_q;
`endif

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// Pipelined WIDTH-input AND reduction, one register stage per FANIN-ary tree level, valid/ready.
// Optional per-transfer OR mode via GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN (adds MODE port).
module gf180mcu_fd_sc_mcu7t5v0__andn_pipe
   import gf180mcu_fd_sc_mcu7t5v0__andn_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FANIN = 4
) (
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
   input  logic             MODE,
`endif
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] A,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic             Z,
   output logic             OUT_VALID,
   input  logic             OUT_READY
);

   localparam int LEVELS  = levels_for(WIDTH, FANIN);
   localparam int TOTAL_W = bit_offset(WIDTH, FANIN, LEVELS + 1);

   // Every tree level packed back to back: operand first, single result bit last.
   logic [TOTAL_W-1:0] lvl_data_s;
   logic [LEVELS:0]    valid_s;
   logic [LEVELS:0]    ready_s;

   assign lvl_data_s[WIDTH-1:0] = A;
   assign valid_s[0]            = IN_VALID;
   assign ready_s[LEVELS]       = OUT_READY;

`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
   logic [LEVELS:0] mode_s;
   assign mode_s[0] = MODE;
`endif

   for (genvar k = 0; k < LEVELS; k++) begin : g_stage
      localparam int IW = (k == 0) ? WIDTH : stage_width(WIDTH, FANIN, k - 1);
      localparam int OW = stage_width(WIDTH, FANIN, k);
      localparam int IO = bit_offset(WIDTH, FANIN, k);
      localparam int OO = bit_offset(WIDTH, FANIN, k + 1);

      gf180mcu_fd_sc_mcu7t5v0__andn_pipe_stage #(
         .IN_W  (IW),
         .OUT_W (OW),
         .FANIN (FANIN)
      ) u_stage (
         .CLK          (CLK),
         .RST          (RST),
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
         .in_mode_i    (mode_s[k]),
         .mode_o       (mode_s[k+1]),
`endif
         .in_data_i    (lvl_data_s[IO +: IW]),
         .in_valid_i   (valid_s[k]),
         .next_ready_i (ready_s[k+1]),
         .ready_o      (ready_s[k]),
         .data_o       (lvl_data_s[OO +: OW]),
         .valid_o      (valid_s[k+1])
      );
   end

   assign Z         = lvl_data_s[TOTAL_W-1];
   assign OUT_VALID = valid_s[LEVELS];
   assign IN_READY  = ready_s[0];

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe.sv
// Directed bench for the pipelined AND reduction: streaming, back-pressure, padding, reset, WIDTH=1.
// OR-mode vectors run only with GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN defined.
module tb_gf180mcu_fd_sc_mcu7t5v0__andn_pipe;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   logic [15:0] a16 = 16'h0000;
   logic        v16 = 1'b0, or16 = 1'b0, m16 = 1'b0;
   logic        ir16, z16, ov16;
   logic [4:0]  a5 = 5'h00;
   logic        v5 = 1'b0, or5 = 1'b0, m5 = 1'b0;
   logic        ir5, z5, ov5;
   logic        a1 = 1'b0, v1 = 1'b0, or1 = 1'b0, m1 = 1'b0;
   logic        ir1, z1, ov1;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(16), .FANIN(4)) u_dut16 (
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
      .MODE(m16),
`endif
      .CLK(CLK), .RST(RST), .A(a16), .IN_VALID(v16), .IN_READY(ir16),
      .Z(z16), .OUT_VALID(ov16), .OUT_READY(or16));

   gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(5), .FANIN(4)) u_dut5 (
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
      .MODE(m5),
`endif
      .CLK(CLK), .RST(RST), .A(a5), .IN_VALID(v5), .IN_READY(ir5),
      .Z(z5), .OUT_VALID(ov5), .OUT_READY(or5));

   gf180mcu_fd_sc_mcu7t5v0__andn_pipe #(.WIDTH(1), .FANIN(4)) u_dut1 (
`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
      .MODE(m1),
`endif
      .CLK(CLK), .RST(RST), .A(a1), .IN_VALID(v1), .IN_READY(ir1),
      .Z(z1), .OUT_VALID(ov1), .OUT_READY(or1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #2 RST = 1'b0;
      chk("rst_ov16", 32'(ov16), 32'd0);
      chk("rst_z16",  32'(z16),  32'd0);
      chk("rst_ir16", 32'(ir16), 32'd1);
      chk("rst_ov5",  32'(ov5),  32'd0);
      chk("rst_ov1",  32'(ov1),  32'd0);

      // Streaming at full throughput.
      or16 = 1'b1; a16 = 16'hFFFF; v16 = 1'b1;
      tick(); a16 = 16'hFFFE;
      tick(); chk("s1_z", 32'(z16), 32'd1); chk("s1_ov", 32'(ov16), 32'd1);
      a16 = 16'hFFFF;
      tick(); chk("s2_z", 32'(z16), 32'd0); chk("s2_ov", 32'(ov16), 32'd1);
      v16 = 1'b0;
      tick(); chk("s3_z", 32'(z16), 32'd1); chk("s3_ov", 32'(ov16), 32'd1);
      tick(); chk("s_drain_ov", 32'(ov16), 32'd0);

      // Back-pressure: two accepted, third refused, both drain in order.
      or16 = 1'b0; a16 = 16'hFFFF; v16 = 1'b1;
      chk("bp_ir0", 32'(ir16), 32'd1);
      tick(); chk("bp_ir1", 32'(ir16), 32'd1);
      a16 = 16'h0000;
      tick(); chk("bp_full_ir", 32'(ir16), 32'd0);
      chk("bp_full_z", 32'(z16), 32'd1); chk("bp_full_ov", 32'(ov16), 32'd1);
      a16 = 16'hFFFF;
      tick(); chk("bp_hold_ir", 32'(ir16), 32'd0);
      chk("bp_hold_z", 32'(z16), 32'd1); chk("bp_hold_ov", 32'(ov16), 32'd1);
      v16 = 1'b0; or16 = 1'b1;
      tick(); chk("bp_r2_z", 32'(z16), 32'd0); chk("bp_r2_ov", 32'(ov16), 32'd1);
      tick(); chk("bp_empty_ov", 32'(ov16), 32'd0);

      // Asynchronous reset with two results in flight.
      or16 = 1'b0; a16 = 16'hFFFF; v16 = 1'b1;
      tick(); tick(); v16 = 1'b0;
      chk("rm_pre_ov", 32'(ov16), 32'd1);
      #3 RST = 1'b1;
      #1 chk("rm_ov", 32'(ov16), 32'd0); chk("rm_z", 32'(z16), 32'd0);
      chk("rm_ir", 32'(ir16), 32'd1);
      #2 RST = 1'b0; or16 = 1'b1;
      tick(); chk("rm_post1_ov", 32'(ov16), 32'd0);
      tick(); chk("rm_post2_ov", 32'(ov16), 32'd0);

      // Padding of the partial group, WIDTH=5.
      or5 = 1'b1; a5 = 5'h1F; v5 = 1'b1;
      tick(); a5 = 5'h0F;
      tick(); chk("pad_1f_z", 32'(z5), 32'd1); chk("pad_1f_ov", 32'(ov5), 32'd1);
      v5 = 1'b0;
      tick(); chk("pad_0f_z", 32'(z5), 32'd0); chk("pad_0f_ov", 32'(ov5), 32'd1);

      // WIDTH=1 degenerates to a single register.
      or1 = 1'b1; a1 = 1'b1; v1 = 1'b1;
      tick(); chk("w1_a1_z", 32'(z1), 32'd1); chk("w1_a1_ov", 32'(ov1), 32'd1);
      a1 = 1'b0;
      tick(); chk("w1_a0_z", 32'(z1), 32'd0);
      v1 = 1'b0;
      tick(); chk("w1_drain_ov", 32'(ov1), 32'd0);

`ifdef GF180MCU_FD_SC_MCU7T5V0__ANDN_PIPE_OR_MODE_EN
      // Mixed modes in flight.
      or16 = 1'b1; v16 = 1'b1; m16 = 1'b1; a16 = 16'h0000;
      tick(); m16 = 1'b0; a16 = 16'h0000;
      tick(); chk("or1_z", 32'(z16), 32'd0); chk("or1_ov", 32'(ov16), 32'd1);
      m16 = 1'b1; a16 = 16'h0100;
      tick(); chk("or2_z", 32'(z16), 32'd0);
      v16 = 1'b0;
      tick(); chk("or3_z", 32'(z16), 32'd1); chk("or3_ov", 32'(ov16), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
